// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, select-width helper and select type for
// the parametrised register file (rf_param, rf_read_port).
package rf_pkg;

  localparam int RF_WIDTH_D  = 16;
  localparam int RF_DEPTH_D  = 8;
  localparam int RF_NUM_RD_D = 2;

  // Select width for a given register count; never below one bit.
  function automatic int rf_selw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [rf_selw(RF_DEPTH_D)-1:0] rf_sel_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of rf_param.
// Ports: sel (register select), regs (flattened storage),
// bypassValid/bypassSel/bypassData (in-flight write), data (read value).
// With RF_BYPASS_EN defined, a matching in-flight write is forwarded.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_D,
  parameter int DEPTH    = RF_DEPTH_D,
  parameter int ZERO_REG = 0,
  parameter int SELW     = rf_selw(DEPTH)
) (
  input  logic [SELW-1:0]        sel,
  input  logic [DEPTH*WIDTH-1:0] regs,
  input  logic                   bypassValid,
  input  logic [SELW-1:0]        bypassSel,
  input  logic [WIDTH-1:0]       bypassData,
  output logic [WIDTH-1:0]       data
);

  always_comb begin
    // Only selects below DEPTH can match, so
    // out-of-range reads fall through as zero.
    data = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (sel == SELW'(r)) begin
        data = regs[r*WIDTH +: WIDTH];
      end
    end
    if (ZERO_REG != 0 && sel == '0) begin
      data = '0;
    end
`ifdef RF_BYPASS_EN
    // bypassValid already excludes dropped
    // and out-of-range writes.
    if (bypassValid && bypassSel == sel) begin
      data = bypassData;
    end
`endif
  end

`ifndef RF_BYPASS_EN
  logic unusedBypass;
  assign unusedBypass = ^{bypassValid, bypassSel, bypassData};
`endif

endmodule

// File: rtl/rf_param.sv
// rf_param: DEPTH x WIDTH register file, NUM_RD combinational read
// ports, one write port, registered out-of-range write error flag.
// Ports: clk, rst (sync, active low), readRegSel/readData (flattened
// per port), writeRegSel, writeData, writeEn, enable, err.
// Optional write-to-read bypass: define RF_BYPASS_EN.
module rf_param
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_D,
  parameter int DEPTH    = RF_DEPTH_D,
  parameter int NUM_RD   = RF_NUM_RD_D,
  parameter int ZERO_REG = 0,
  parameter int SELW     = rf_selw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*SELW-1:0]  readRegSel,
  output logic [NUM_RD*WIDTH-1:0] readData,
  input  logic [SELW-1:0]         writeRegSel,
  input  logic [WIDTH-1:0]        writeData,
  input  logic                    writeEn,
  input  logic                    enable,
  output logic                    err
);

  localparam logic [SELW:0] DEPTH_V = (SELW+1)'(DEPTH);

  logic [DEPTH*WIDTH-1:0] regs;
  logic inRange;
  logic isZero;
  logic writeHit;
  logic bypassValid;

  assign inRange  = {1'b0, writeRegSel} < DEPTH_V;
  assign isZero   = (ZERO_REG != 0) && (writeRegSel == '0);
  assign writeHit = enable && writeEn && inRange && !isZero;
  assign bypassValid = rst && writeHit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '0;
      err  <= 1'b0;
    end else if (enable) begin
      err <= writeEn && !inRange;
      for (int r = 0; r < DEPTH; r++) begin
        if (writeHit && writeRegSel == SELW'(r)) begin
          regs[r*WIDTH +: WIDTH] <= writeData;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRead
    rf_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .SELW    (SELW)
    ) uPort (
      .sel        (readRegSel[p*SELW +: SELW]),
      .regs       (regs),
      .bypassValid(bypassValid),
      .bypassSel  (writeRegSel),
      .bypassData (writeData),
      .data       (readData[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: three rf_param configurations (8x16 2-port, 6x16
// zero-reg 2-port, 16x32 4-port) against a behavioural model.
module tb_rf_param;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]   aRs;
  logic [31:0]  aRd;
  logic [2:0]   aWs;
  logic [15:0]  aWd;
  logic         aWe, aEn, aErr;
  logic [5:0]   bRs;
  logic [31:0]  bRd;
  logic [2:0]   bWs;
  logic [15:0]  bWd;
  logic         bWe, bEn, bErr;
  logic [15:0]  cRs;
  logic [127:0] cRd;
  logic [3:0]   cWs;
  logic [31:0]  cWd;
  logic         cWe, cEn, cErr;

  rf_param #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(0)) dutA (
    .clk(clk), .rst(rst), .readRegSel(aRs), .readData(aRd),
    .writeRegSel(aWs), .writeData(aWd), .writeEn(aWe),
    .enable(aEn), .err(aErr));

  rf_param #(.WIDTH(16), .DEPTH(6), .NUM_RD(2), .ZERO_REG(1)) dutB (
    .clk(clk), .rst(rst), .readRegSel(bRs), .readData(bRd),
    .writeRegSel(bWs), .writeData(bWd), .writeEn(bWe),
    .enable(bEn), .err(bErr));

  rf_param #(.WIDTH(32), .DEPTH(16), .NUM_RD(4), .ZERO_REG(0)) dutC (
    .clk(clk), .rst(rst), .readRegSel(cRs), .readData(cRd),
    .writeRegSel(cWs), .writeData(cWd), .writeEn(cWe),
    .enable(cEn), .err(cErr));

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents and expected err per instance.
  logic [15:0] mA [8];
  logic [15:0] mB [6];
  logic [31:0] mC [16];
  logic eA, eB, eC;

  always @(posedge clk) begin
    if (!rst) begin
      foreach (mA[i]) mA[i] = '0;
      foreach (mB[i]) mB[i] = '0;
      foreach (mC[i]) mC[i] = '0;
      eA = 1'b0;
      eB = 1'b0;
      eC = 1'b0;
    end else begin
      if (aEn) begin
        eA = aWe && (int'(aWs) >= 8);
        if (aWe && int'(aWs) < 8) mA[aWs] = aWd;
      end
      if (bEn) begin
        eB = bWe && (int'(bWs) >= 6);
        if (bWe && int'(bWs) < 6 && bWs != 0) mB[bWs] = bWd;
      end
      if (cEn) begin
        eC = cWe && (int'(cWs) >= 16);
        if (cWe && int'(cWs) < 16) mC[cWs] = cWd;
      end
    end
  end

  function automatic logic [15:0] expA(input logic [2:0] s);
    logic [15:0] v;
    v = (int'(s) < 8) ? mA[s] : 16'h0;
    if (BYP && rst && aEn && aWe && aWs == s) v = aWd;
    return v;
  endfunction

  function automatic logic [15:0] expB(input logic [2:0] s);
    logic [15:0] v;
    v = (int'(s) < 6 && s != 0) ? mB[s] : 16'h0;
    if (BYP && rst && bEn && bWe && int'(bWs) < 6 && bWs != 0 && bWs == s)
      v = bWd;
    return v;
  endfunction

  function automatic logic [31:0] expC(input logic [3:0] s);
    logic [31:0] v;
    v = mC[s];
    if (BYP && rst && cEn && cWe && cWs == s) v = cWd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkReads(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s A rd%0d", tag, i), 32'(aRd[i*16 +: 16]),
          32'(expA(aRs[i*3 +: 3])));
      chk($sformatf("%s B rd%0d", tag, i), 32'(bRd[i*16 +: 16]),
          32'(expB(bRs[i*3 +: 3])));
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s C rd%0d", tag, i), cRd[i*32 +: 32],
          expC(cRs[i*4 +: 4]));
  endtask

  task automatic checkErr(input string tag);
    chk({tag, " A err"}, 32'(aErr), 32'(eA));
    chk({tag, " B err"}, 32'(bErr), 32'(eB));
    chk({tag, " C err"}, 32'(cErr), 32'(eC));
  endtask

  task automatic idle();
    aEn = 1'b1; aWe = 1'b0; aWs = '0; aWd = '0; aRs = '0;
    bEn = 1'b1; bWe = 1'b0; bWs = '0; bWd = '0; bRs = '0;
    cEn = 1'b1; cWe = 1'b0; cWs = '0; cWd = '0; cRs = '0;
  endtask

  typedef struct {
    logic        en;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [2:0]  rs0;
    logic [2:0]  rs1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Reads are checked before the edge, state after it.
    vecs[0] = '{1, 1, 3'd5, 16'hBEEF, 3'd5, 3'd5,
                BYP ? 16'hBEEF : 16'h0, BYP ? 16'hBEEF : 16'h0};
    vecs[1] = '{1, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{0, 1, 3'd5, 16'h1111, 3'd5, 3'd4, 16'hBEEF, 16'h0};
    vecs[3] = '{1, 0, 3'd0, 16'h0000, 3'd5, 3'd3, 16'hBEEF, 16'h0};
    vecs[4] = '{1, 1, 3'd3, 16'h00AA, 3'd3, 3'd5,
                BYP ? 16'h00AA : 16'h0, 16'hBEEF};
    vecs[5] = '{1, 1, 3'd3, 16'h5555, 3'd3, 3'd3,
                BYP ? 16'h5555 : 16'h00AA, BYP ? 16'h5555 : 16'h00AA};
    vecs[6] = '{1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h5555, 16'h5555};

    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkReads("init");
    checkErr("init");

    // Reset clears every register and overrides a same-cycle write.
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      aWe = 1'b1; aWs = r[2:0]; aWd = 16'h1234;
    end
    @(negedge clk);
    aWe = 1'b0; aRs = {3'd7, 3'd2};
    #1 chk("fill rd0", 32'(aRd[15:0]), 32'h1234);
    chk("fill rd1", 32'(aRd[31:16]), 32'h1234);
    aWe = 1'b1; aWs = 3'd4; aWd = 16'h9999; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; aWe = 1'b0;
    for (int r = 0; r < 8; r++) begin
      aRs = {r[2:0], r[2:0]};
      #1 chk($sformatf("rst reg%0d p0", r), 32'(aRd[15:0]), 32'h0);
      chk($sformatf("rst reg%0d p1", r), 32'(aRd[31:16]), 32'h0);
    end
    chk("rst err", 32'(aErr), 32'h0);

    // Table-driven write/read/hazard sequence on the default instance.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      aEn = vecs[v].en; aWe = vecs[v].we;
      aWs = vecs[v].ws; aWd = vecs[v].wd;
      aRs = {vecs[v].rs1, vecs[v].rs0};
      #1 chk($sformatf("vec%0d rd0", v), 32'(aRd[15:0]), 32'(vecs[v].e0));
      chk($sformatf("vec%0d rd1", v), 32'(aRd[31:16]), 32'(vecs[v].e1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d err", v), 32'(aErr), 32'h0);
    end

    // Range error on the 6-deep instance.
    @(negedge clk);
    aEn = 1'b1; aWe = 1'b0;
    bEn = 1'b1; bWe = 1'b1; bWs = 3'd2; bWd = 16'h0BB2;
    @(negedge clk);
    bWs = 3'd7; bWd = 16'hABCD; bRs = {3'd2, 3'd7};
    #1 chk("oor rd sel7", 32'(bRd[15:0]), 32'h0);
    chk("oor rd sel2", 32'(bRd[31:16]), 32'h0BB2);
    @(posedge clk); #1;
    chk("oor err set", 32'(bErr), 32'h1);
    @(negedge clk);
    bWe = 1'b0;
    @(posedge clk); #1;
    chk("oor err clear", 32'(bErr), 32'h0);
    for (int s = 0; s < 8; s++) begin
      bRs = {s[2:0], s[2:0]};
      #1 chk($sformatf("oor keep reg%0d", s), 32'(bRd[15:0]),
             (s == 2) ? 32'h0BB2 : 32'h0);
    end
    @(negedge clk);
    bEn = 1'b0; bWe = 1'b1; bWs = 3'd7;
    @(posedge clk); #1;
    chk("oor disabled err", 32'(bErr), 32'h0);
    @(negedge clk);
    bEn = 1'b1; bWs = 3'd6;
    @(posedge clk); #1;
    chk("oor err sel6", 32'(bErr), 32'h1);
    @(negedge clk);
    bEn = 1'b0; bWe = 1'b0;
    @(posedge clk); #1;
    chk("err hold", 32'(bErr), 32'h1);
    @(negedge clk);
    bEn = 1'b1;
    @(posedge clk); #1;
    chk("err drop", 32'(bErr), 32'h0);

    // Hardwired zero register versus an ordinary register 0.
    @(negedge clk);
    bWe = 1'b1; bWs = 3'd0; bWd = 16'hFFFF;
    aWe = 1'b1; aWs = 3'd0; aWd = 16'hFFFF;
    @(negedge clk);
    bWe = 1'b0; aWe = 1'b0; bRs = '0; aRs = '0;
    #1 chk("zreg read", 32'(bRd[15:0]), 32'h0);
    chk("zreg err", 32'(bErr), 32'h0);
    chk("reg0 read", 32'(aRd[15:0]), 32'hFFFF);

    // Wide, four-port instance.
    @(negedge clk);
    cWe = 1'b1; cWs = 4'd15; cWd = 32'hDEADBEEF;
    @(negedge clk);
    cWs = 4'd0; cWd = 32'h1;
    @(negedge clk);
    cWe = 1'b0; cRs = {4'd2, 4'd15, 4'd0, 4'd15};
    #1 chk("wide p0", cRd[31:0], 32'hDEADBEEF);
    chk("wide p1", cRd[63:32], 32'h1);
    chk("wide p2", cRd[95:64], 32'hDEADBEEF);
    chk("wide p3", cRd[127:96], 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) != 0);
      aEn = ($urandom_range(0, 3) != 0); aWe = 1'($urandom);
      aWs = 3'($urandom); aWd = 16'($urandom); aRs = 6'($urandom);
      bEn = ($urandom_range(0, 3) != 0); bWe = 1'($urandom);
      bWs = 3'($urandom); bWd = 16'($urandom); bRs = 6'($urandom);
      cEn = ($urandom_range(0, 3) != 0); cWe = 1'($urandom);
      cWs = 4'($urandom); cWd = $urandom; cRs = 16'($urandom);
      #1 checkReads("rnd");
      @(posedge clk); #1;
      checkErr("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
